// File: rtl/traffic_light_monitor.sv
// Traffic light monitor: watches the light/countdown pair coming from a
// signal controller, grants pedestrian walk during long enough red phases,
// drives a two-digit BCD countdown display and latches the first fault seen
// (bad light encoding, illegal sequence, broken countdown or stuck inputs).
module traffic_light_monitor #(
  parameter int WDOG_CYCLES = 100000000,
  parameter int WALK_MIN    = 3
) (
  input  logic       strt_clk,
  input  logic       reset,
  input  logic [2:0] light,
  input  logic [4:0] remaining_time,
  output logic       walk,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [7:0] cycle_count
);

  localparam int              WDOG_W    = $clog2(WDOG_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);
  localparam logic [4:0]      WALK_MIN_T = 5'(WALK_MIN);

  localparam logic [2:0] LIGHT_RED = 3'b001;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_GRN = 3'b100;

  localparam logic [2:0] CODE_ENC  = 3'b001;
  localparam logic [2:0] CODE_SEQ  = 3'b010;
  localparam logic [2:0] CODE_CNT  = 3'b011;
  localparam logic [2:0] CODE_WDOG = 3'b100;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [2:0]        prev_light_q, prev_light_d;
  logic [4:0]        prev_time_q, prev_time_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              walk_q, walk_d;
  logic              fault_q, fault_d;
  logic [2:0]        fault_code_q, fault_code_d;
  logic [7:0]        cycle_count_q, cycle_count_d;
  logic [3:0]        bcd_tens_q, bcd_tens_d;
  logic [3:0]        bcd_ones_q, bcd_ones_d;

  logic input_event;
  logic light_chg;
  logic err_enc;
  logic err_seq;
  logic err_cnt;
  logic err_wdog;
  logic red_to_green;

  // Exactly one lamp lit.
  function automatic logic is_onehot(input logic [2:0] l);
    return (l == LIGHT_RED) || (l == LIGHT_YEL) || (l == LIGHT_GRN);
  endfunction

  // The only allowed phase order is green -> yellow -> red -> green.
  function automatic logic legal_step(input logic [2:0] from_l, input logic [2:0] to_l);
    return ((from_l == LIGHT_GRN) && (to_l == LIGHT_YEL)) ||
           ((from_l == LIGHT_YEL) && (to_l == LIGHT_RED)) ||
           ((from_l == LIGHT_RED) && (to_l == LIGHT_GRN));
  endfunction

  // Binary (0..31) to two BCD digits, packed {tens, ones}.
  function automatic logic [7:0] to_bcd(input logic [4:0] t);
    logic [3:0] tens;
    logic [4:0] rem;
    if (t >= 5'd30) begin
      tens = 4'd3;
      rem  = t - 5'd30;
    end else if (t >= 5'd20) begin
      tens = 4'd2;
      rem  = t - 5'd20;
    end else if (t >= 5'd10) begin
      tens = 4'd1;
      rem  = t - 5'd10;
    end else begin
      tens = 4'd0;
      rem  = t;
    end
    return {tens, rem[3:0]};
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [WDOG_W-1:0] sat_inc(input logic [WDOG_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // Fault detectors comparing the current inputs against last cycle's.
  always_comb begin
    light_chg   = (light != prev_light_q);
    input_event = light_chg || (remaining_time != prev_time_q);
    err_enc     = !is_onehot(light);
    err_seq     = light_chg &&
                  !(legal_step(prev_light_q, light) && (prev_time_q <= 5'd1));
    // A countdown step from zero is never legal; otherwise only t-1 is.
    err_cnt     = !light_chg && (remaining_time != prev_time_q) &&
                  ((prev_time_q == 5'd0) || (remaining_time != prev_time_q - 5'd1));
    err_wdog    = !input_event && (wdog_q >= WDOG_LAST);
  end

  // State register.
  always_ff @(posedge strt_clk) begin
    if (reset) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and fault code latch; earlier checks win when several fire.
  always_comb begin
    state_d      = state_q;
    fault_code_d = fault_code_q;
    case (state_q)
      INIT: begin
        if (is_onehot(light)) begin
          state_d = TRACK;
        end
      end
      TRACK: begin
        if (err_enc) begin
          state_d      = FAULT;
          fault_code_d = CODE_ENC;
        end else if (err_seq) begin
          state_d      = FAULT;
          fault_code_d = CODE_SEQ;
        end else if (err_cnt) begin
          state_d      = FAULT;
          fault_code_d = CODE_CNT;
        end else if (err_wdog) begin
          state_d      = FAULT;
          fault_code_d = CODE_WDOG;
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  // Datapath next values; walk and the display key off the next state so
  // they blank in the same cycle the fault is taken.
  always_comb begin
    prev_light_d  = light;
    prev_time_d   = remaining_time;
    wdog_d        = ((state_q != TRACK) || input_event) ? '0 : sat_inc(wdog_q);
    red_to_green  = (state_q == TRACK) && (state_d == TRACK) &&
                    (prev_light_q == LIGHT_RED) && (light == LIGHT_GRN);
    cycle_count_d = red_to_green ? cycle_count_q + 8'd1 : cycle_count_q;
    walk_d        = (state_d == TRACK) && (light == LIGHT_RED) &&
                    (remaining_time >= WALK_MIN_T);
    fault_d       = (state_d == FAULT);
    if (state_d == FAULT) begin
      {bcd_tens_d, bcd_ones_d} = 8'hFF;
    end else begin
      {bcd_tens_d, bcd_ones_d} = to_bcd(remaining_time);
    end
  end

  // Datapath registers.
  always_ff @(posedge strt_clk) begin
    if (reset) begin
      prev_light_q  <= '0;
      prev_time_q   <= '0;
      wdog_q        <= '0;
      walk_q        <= 1'b0;
      fault_q       <= 1'b0;
      fault_code_q  <= '0;
      cycle_count_q <= '0;
      bcd_tens_q    <= '0;
      bcd_ones_q    <= '0;
    end else begin
      prev_light_q  <= prev_light_d;
      prev_time_q   <= prev_time_d;
      wdog_q        <= wdog_d;
      walk_q        <= walk_d;
      fault_q       <= fault_d;
      fault_code_q  <= fault_code_d;
      cycle_count_q <= cycle_count_d;
      bcd_tens_q    <= bcd_tens_d;
      bcd_ones_q    <= bcd_ones_d;
    end
  end

  assign walk        = walk_q;
  assign fault       = fault_q;
  assign fault_code  = fault_code_q;
  assign cycle_count = cycle_count_q;
  assign bcd_tens    = bcd_tens_q;
  assign bcd_ones    = bcd_ones_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor with a short watchdog.
module tb_traffic_light_monitor;

  localparam logic [2:0] R = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b100;

  logic       strt_clk;
  logic       reset;
  logic [2:0] light;
  logic [4:0] remaining_time;
  logic       walk;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_ones;
  logic       fault;
  logic [2:0] fault_code;
  logic [7:0] cycle_count;

  int total = 0;
  int bad   = 0;

  traffic_light_monitor #(
    .WDOG_CYCLES(16),
    .WALK_MIN   (3)
  ) dut (
    .strt_clk      (strt_clk),
    .reset         (reset),
    .light         (light),
    .remaining_time(remaining_time),
    .walk          (walk),
    .bcd_tens      (bcd_tens),
    .bcd_ones      (bcd_ones),
    .fault         (fault),
    .fault_code    (fault_code),
    .cycle_count   (cycle_count)
  );

  initial strt_clk = 1'b0;
  always #5 strt_clk = ~strt_clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs, take one rising edge, sample on the falling edge.
  task automatic tick(input logic [2:0] l, input logic [4:0] t);
    light          = l;
    remaining_time = t;
    @(posedge strt_clk);
    @(negedge strt_clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(3'b000, 5'd0);
    tick(3'b000, 5'd0);
    reset = 1'b0;
  endtask

  task automatic chk_all(input string tag, input logic w, input logic f,
                         input logic [2:0] code, input logic [3:0] tens,
                         input logic [3:0] ones, input logic [7:0] cnt);
    chk({tag, ".walk"}, 8'(walk), 8'(w));
    chk({tag, ".fault"}, 8'(fault), 8'(f));
    chk({tag, ".code"}, 8'(fault_code), 8'(code));
    chk({tag, ".tens"}, 8'(bcd_tens), 8'(tens));
    chk({tag, ".ones"}, 8'(bcd_ones), 8'(ones));
    chk({tag, ".cnt"}, cycle_count, cnt);
  endtask

  initial begin
    reset          = 1'b1;
    light          = 3'b000;
    remaining_time = 5'd0;
    @(negedge strt_clk);

    // Full legal phase: green 5..0, yellow 2..0, red 9..0, green.
    do_reset();
    chk_all("reset0", 1'b0, 1'b0, 3'd0, 4'd0, 4'd0, 8'd0);
    tick(G, 5'd5);
    chk_all("enter_track", 1'b0, 1'b0, 3'd0, 4'd0, 4'd5, 8'd0);
    for (int t = 4; t >= 0; t--) begin
      tick(G, 5'(t));
      chk("green.ones", 8'(bcd_ones), 8'(t));
      chk("green.fault", 8'(fault), 8'd0);
    end
    light          = Y;
    remaining_time = 5'd2;
    #1;
    chk("bcd_lag_before_edge", 8'(bcd_ones), 8'd0);
    tick(Y, 5'd2);
    chk("bcd_lag_after_edge", 8'(bcd_ones), 8'd2);
    tick(Y, 5'd1);
    tick(Y, 5'd0);
    chk("yellow.fault", 8'(fault), 8'd0);
    for (int t = 9; t >= 0; t--) begin
      tick(R, 5'(t));
      chk("red.walk", 8'(walk), (t >= 3) ? 8'd1 : 8'd0);
      chk("red.ones", 8'(bcd_ones), 8'(t));
      chk("red.fault", 8'(fault), 8'd0);
    end
    tick(G, 5'd7);
    chk_all("phase_done", 1'b0, 1'b0, 3'd0, 4'd0, 4'd7, 8'd1);

    // Green at 4 jumps straight to red: sequence fault, walk suppressed.
    tick(G, 5'd6);
    tick(G, 5'd5);
    tick(G, 5'd4);
    tick(R, 5'd4);
    chk_all("seq_fault", 1'b0, 1'b1, 3'b010, 4'hF, 4'hF, 8'd1);
    tick(R, 5'd3);
    tick(G, 5'd2);
    chk_all("seq_sticky", 1'b0, 1'b1, 3'b010, 4'hF, 4'hF, 8'd1);

    // INIT performs no checks but still converts; then a countdown fault.
    do_reset();
    chk_all("reset1", 1'b0, 1'b0, 3'd0, 4'd0, 4'd0, 8'd0);
    tick(3'b011, 5'd23);
    chk_all("init_23", 1'b0, 1'b0, 3'd0, 4'd2, 4'd3, 8'd0);
    tick(3'b011, 5'd31);
    chk_all("init_31", 1'b0, 1'b0, 3'd0, 4'd3, 4'd1, 8'd0);
    tick(R, 5'd7);
    chk_all("red7", 1'b1, 1'b0, 3'd0, 4'd0, 4'd7, 8'd0);
    tick(R, 5'd5);
    chk_all("cnt_fault", 1'b0, 1'b1, 3'b011, 4'hF, 4'hF, 8'd0);
    do_reset();
    chk_all("reset_from_fault", 1'b0, 1'b0, 3'd0, 4'd0, 4'd0, 8'd0);
    tick(3'b110, 5'd0);
    chk("still_init.fault", 8'(fault), 8'd0);

    // Bad encoding coinciding with a time jump: encoding code wins.
    do_reset();
    tick(R, 5'd9);
    tick(R, 5'd8);
    tick(3'b011, 5'd2);
    chk_all("enc_prio", 1'b0, 1'b1, 3'b001, 4'hF, 4'hF, 8'd0);

    // Watchdog: inputs frozen after the last event.
    do_reset();
    tick(R, 5'd9);
    tick(R, 5'd8);
    repeat (15) tick(R, 5'd8);
    chk_all("wdog_15", 1'b1, 1'b0, 3'd0, 4'd0, 4'd8, 8'd0);
    tick(R, 5'd8);
    chk_all("wdog_16", 1'b0, 1'b1, 3'b100, 4'hF, 4'hF, 8'd0);

    // 256 shortest legal phases: counter wraps back to zero.
    do_reset();
    tick(G, 5'd0);
    for (int i = 1; i <= 256; i++) begin
      tick(Y, 5'd0);
      tick(R, 5'd0);
      tick(G, 5'd0);
      if (i == 1)   chk("wrap.cnt1", cycle_count, 8'd1);
      if (i == 255) chk("wrap.cnt255", cycle_count, 8'd255);
    end
    chk_all("wrap_256", 1'b0, 1'b0, 3'd0, 4'd0, 4'd0, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
